seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit 7-segment display. It shares one BCD-to-7-segment decoder among NUM_DIGITS digit positions. It holds a double-buffered display word, cycles a one-hot digit enable, and inserts a blanking gap between digits to suppress ghosting. It sits between the register that produces display values and the board's segment and anode pins.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/bcd_seg_dec.sv | 28 ++
 rtl/seg_scan_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the 7-segment scan controller.
//   SEG_0..SEG_9, SEG_BLANK : {a,b,c,d,e,f,g} active-high segment patterns
//   scan_state_e            : scan controller FSM state
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/bcd_seg_dec.sv
// bcd_seg_dec: combinational BCD to 7-segment decoder.
//   bcd : 4-bit input code
//   seg : {a,b,c,d,e,f,g} active-high; blank for codes 10..15
module bcd_seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a multi-digit
// 7-segment display with a double-buffered display word.
//   clk, rst    : clock, synchronous active-high reset
//   load        : strobe capturing data_in/dp_in/blank_lz into shadow
//   data_in     : BCD nibbles, digit 0 in bits [3:0]
//   dp_in       : decimal point per digit
//   blank_lz    : leading-zero blanking enable
//   seg, dp     : segments / decimal point of the lit digit (registered)
//   digit_en    : one-hot digit enable, zero during gaps and idle
//   frame_start : one-cycle pulse on entry to digit 0's slot
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 16,
  parameter int BLANK_GAP  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int MAXC = (SCAN_DIV > BLANK_GAP) ? SCAN_DIV : BLANK_GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SCAN_LD  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((BLANK_GAP > 0) ? BLANK_GAP - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic                  sh_blz_q, sh_blz_d, act_blz_q, act_blz_d;
  logic                  pend_q, pend_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic                  fs_q, fs_d;

  logic                  commit;
  logic                  wrap;
  logic [IW-1:0]         next_idx;
  logic [3:0]            nib;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [NUM_DIGITS-1:0] onehot;
  logic                  sel_dp, sel_lz, upper_zero;

  assign wrap     = (idx_q == LAST_IDX);
  assign next_idx = wrap ? '0 : idx_q + 1'b1;

  // Slot sequencing. commit marks entry into digit 0's slot: the only point
  // where the active buffer may change, so a frame is never torn.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SCAN;
          idx_d   = '0;
          cnt_d   = SCAN_LD;
          commit  = 1'b1;
        end
      end
      SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (BLANK_GAP == 0) begin
          idx_d  = next_idx;
          cnt_d  = SCAN_LD;
          commit = wrap;
        end else begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = SCAN;
          idx_d   = next_idx;
          cnt_d   = SCAN_LD;
          commit  = wrap;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Double buffer. Leaving IDLE commits the load being taken that cycle
  // directly; at later frame boundaries a coincident load only reaches
  // shadow and waits for the following boundary.
  always_comb begin
    sh_data_d  = load ? data_in  : sh_data_q;
    sh_dp_d    = load ? dp_in    : sh_dp_q;
    sh_blz_d   = load ? blank_lz : sh_blz_q;
    pend_d     = pend_q | load;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_blz_d  = act_blz_q;
    if (commit) begin
      if (state_q == IDLE) begin
        act_data_d = data_in;
        act_dp_d   = dp_in;
        act_blz_d  = blank_lz;
        pend_d     = 1'b0;
      end else begin
        act_data_d = sh_data_q;
        act_dp_d   = sh_dp_q;
        act_blz_d  = sh_blz_q;
        pend_d     = load;
      end
    end
  end

  // Digit i>0 is blanked when it and every nibble above it are zero.
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero  = upper_zero & (act_data_d[4*i +: 4] == 4'd0);
      lz_blank[i] = act_blz_d & upper_zero;
    end
  end

  // Outputs are computed from next-cycle state and registered, so the pins
  // see no combinational path from any input.
  always_comb begin
    nib    = '0;
    sel_dp = 1'b0;
    sel_lz = 1'b0;
    onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nib       = act_data_d[4*i +: 4];
        sel_dp    = act_dp_d[i];
        sel_lz    = lz_blank[i];
        onehot[i] = 1'b1;
      end
    end
  end

  bcd_seg_dec u_dec (
    .bcd (nib),
    .seg (dec_seg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    en_d  = '0;
    fs_d  = 1'b0;
    if (state_d == SCAN) begin
      en_d  = onehot;
      seg_d = sel_lz ? SEG_BLANK : dec_seg;
      dp_d  = sel_dp;
      fs_d  = commit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_blz_q   <= 1'b0;
      pend_q     <= 1'b0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_blz_q  <= 1'b0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      en_q       <= '0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_blz_q   <= sh_blz_d;
      pend_q     <= pend_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      act_blz_q  <= act_blz_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      en_q       <= en_d;
      fs_q       <= fs_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign digit_en    = en_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl. Instance a uses
// BLANK_GAP=1, instance b uses BLANK_GAP=0; both NUM_DIGITS=4, SCAN_DIV=4.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_a, load_b;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        blank_lz;

  logic [6:0]  a_seg, b_seg;
  logic        a_dp, b_dp, a_fs, b_fs;
  logic [3:0]  a_en, b_en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_GAP(1)) u_a (
    .clk(clk), .rst(rst), .load(load_a), .data_in(data_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(a_seg), .dp(a_dp), .digit_en(a_en),
    .frame_start(a_fs)
  );

  seg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_GAP(0)) u_b (
    .clk(clk), .rst(rst), .load(load_b), .data_in(data_in), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(b_seg), .dp(b_dp), .digit_en(b_en),
    .frame_start(b_fs)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] tb_dec(input logic [3:0] n);
    case (n)
      4'd0: return 7'h7E;
      4'd1: return 7'h30;
      4'd2: return 7'h6D;
      4'd3: return 7'h79;
      4'd4: return 7'h33;
      4'd5: return 7'h5B;
      4'd6: return 7'h5F;
      4'd7: return 7'h70;
      4'd8: return 7'h7F;
      4'd9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  // Checks one full frame starting at the sampled first cycle of slot 0.
  // Optional loads are presented at frame cycles k1/k2 (-1 = none).
  task automatic check_frame(input string tag, input int sel,
                             input logic [15:0] d, input logic [3:0] dpv,
                             input logic blz, input int gap,
                             input int k1, input logic [15:0] v1,
                             input int k2, input logic [15:0] v2,
                             input logic [3:0] dpl, input logic blzl);
    int slot_len, slot, w;
    logic [3:0]  e_en, g_en;
    logic [6:0]  e_seg, g_seg;
    logic        e_dp, g_dp, e_fs, g_fs, blank;
    logic [15:0] upper;
    slot_len = 4 + gap;
    for (int k = 0; k < 4 * slot_len; k++) begin
      slot = k / slot_len;
      w    = k % slot_len;
      e_en = '0; e_seg = '0; e_dp = 1'b0;
      e_fs = (k == 0);
      if (w < 4) begin
        upper = d >> (4 * slot);
        blank = blz && (slot > 0) && (upper == 16'h0);
        e_en  = 4'b0001 << slot;
        e_seg = blank ? 7'h00 : tb_dec(upper[3:0]);
        e_dp  = dpv[slot];
      end
      g_en  = sel ? b_en  : a_en;
      g_seg = sel ? b_seg : a_seg;
      g_dp  = sel ? b_dp  : a_dp;
      g_fs  = sel ? b_fs  : a_fs;
      chk($sformatf("%s k%0d en",  tag, k), 32'(g_en),  32'(e_en));
      chk($sformatf("%s k%0d seg", tag, k), 32'(g_seg), 32'(e_seg));
      chk($sformatf("%s k%0d dp",  tag, k), 32'(g_dp),  32'(e_dp));
      chk($sformatf("%s k%0d fs",  tag, k), 32'(g_fs),  32'(e_fs));
      load_a = 1'b0;
      load_b = 1'b0;
      if (k == k1 || k == k2) begin
        data_in  = (k == k1) ? v1 : v2;
        dp_in    = dpl;
        blank_lz = blzl;
        if (sel != 0) load_b = 1'b1;
        else          load_a = 1'b1;
      end
      tick();
    end
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  initial begin
    int   fs_cnt;
    logic lit;
    rst = 1'b1; load_a = 1'b0; load_b = 1'b0;
    data_in = '0; dp_in = '0; blank_lz = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst en",  32'(a_en),  32'h0);
    chk("rst seg", 32'(a_seg), 32'h0);
    chk("rst dp",  32'(a_dp),  32'h0);
    chk("rst fs",  32'(a_fs),  32'h0);

    // Idle without load: stays dark.
    fs_cnt = 0; lit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      fs_cnt += int'(a_fs) + int'(b_fs);
      lit |= (|a_en) | (|a_seg) | a_dp | (|b_en) | (|b_seg) | b_dp;
    end
    chk("idle fs count", 32'(fs_cnt), 32'h0);
    chk("idle lit",      32'(lit),    32'h0);

    // First load from IDLE: visible on the next cycle.
    data_in = 16'h1234; dp_in = 4'b0010; blank_lz = 1'b0; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    chk("first en",  32'(a_en),  32'h1);
    chk("first seg", 32'(a_seg), 32'h33);
    chk("first fs",  32'(a_fs),  32'h1);
    check_frame("f1", 0, 16'h1234, 4'b0010, 1'b0, 1, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
    check_frame("f2", 0, 16'h1234, 4'b0010, 1'b0, 1, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
    // Two loads while digit 2 is lit: frame untouched, only the last survives.
    check_frame("f3", 0, 16'h1234, 4'b0010, 1'b0, 1, 11, 16'h5678, 13, 16'h9999, 4'b0100, 1'b0);
    check_frame("f4", 0, 16'h9999, 4'b0100, 1'b0, 1, 0, 16'h0070, -1, 16'h0, 4'b0000, 1'b1);
    check_frame("f5 lz", 0, 16'h0070, 4'b0000, 1'b1, 1, 5, 16'h0070, -1, 16'h0, 4'b0000, 1'b0);
    // Load on the last cycle coincides with the commit edge: deferred a frame.
    check_frame("f6", 0, 16'h0070, 4'b0000, 1'b0, 1, 19, 16'h00AF, -1, 16'h0, 4'b0011, 1'b0);
    check_frame("f7", 0, 16'h0070, 4'b0000, 1'b0, 1, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
    check_frame("f8 hex", 0, 16'h00AF, 4'b0011, 1'b0, 1, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);

    // Reset during digit 1's slot with a coincident load.
    for (int i = 0; i < 6; i++) tick();
    chk("pre-rst en", 32'(a_en), 32'h2);
    rst = 1'b1; load_a = 1'b1; data_in = 16'h8888; dp_in = 4'b1111;
    tick();
    rst = 1'b0; load_a = 1'b0;
    chk("mid rst en",  32'(a_en),  32'h0);
    chk("mid rst seg", 32'(a_seg), 32'h0);
    chk("mid rst dp",  32'(a_dp),  32'h0);
    chk("mid rst fs",  32'(a_fs),  32'h0);
    fs_cnt = 0; lit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      fs_cnt += int'(a_fs);
      lit |= (|a_en) | (|a_seg) | a_dp;
    end
    chk("post rst fs count", 32'(fs_cnt), 32'h0);
    chk("post rst lit",      32'(lit),    32'h0);
    data_in = 16'h2468; dp_in = 4'b0000; blank_lz = 1'b0; load_a = 1'b1;
    tick();
    load_a = 1'b0;
    chk("restart en",  32'(a_en),  32'h1);
    chk("restart seg", 32'(a_seg), 32'h7F);
    chk("restart fs",  32'(a_fs),  32'h1);
    check_frame("f9", 0, 16'h2468, 4'b0000, 1'b0, 1, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);

    // No-gap instance: 16-cycle frame, never all-off.
    data_in = 16'h00AF; dp_in = 4'b0011; blank_lz = 1'b0; load_b = 1'b1;
    tick();
    load_b = 1'b0;
    check_frame("g0 f1", 1, 16'h00AF, 4'b0011, 1'b0, 0, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
    check_frame("g0 f2", 1, 16'h00AF, 4'b0011, 1'b0, 0, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
